// File: rtl/flappy_pkg.sv
// Shared playfield constants and game-state encoding for the Flappy Bird blocks.
// The renderer, collision checker and pipe scheduler all take their geometry from here.
package flappy_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HALT = 2'd2;

    localparam int unsigned N_SLOTS    = 3;
    localparam int unsigned MAX_X      = 320;
    localparam int unsigned MIN_X      = 57;
    localparam int unsigned MIN_Y      = 45;
    localparam int unsigned WIDTH_PIPE = 41;
    localparam int unsigned SPACING    = 110;
    localparam int unsigned BIRD_X     = 120;

    localparam int unsigned H_LO  = 180;
    localparam int unsigned H_HI  = 280;
    localparam int unsigned H_DEF = 205;

    localparam logic [8:0] LFSR_SEED = 9'h1A5;

    // Out-of-range raw samples fall back to a fixed, always-playable gap.
    function automatic logic [9:0] height_sample(
        input logic [8:0] raw,
        input logic [9:0] lo,
        input logic [9:0] hi,
        input logic [9:0] dflt
    );
        logic [9:0] ext;
        ext = {1'b0, raw};
        return ((ext >= lo) && (ext <= hi)) ? ext : dflt;
    endfunction

endpackage

// File: rtl/pipe_lfsr.sv
// Free-running 9-bit Fibonacci LFSR (x^9 + x^5 + 1) feeding the pipe gap height.
// It steps on every clock, independent of game state.
module pipe_lfsr
    import flappy_pkg::*;
#(
    parameter logic [8:0] SEED = LFSR_SEED
) (
    input  logic       clk,
    input  logic       reset,
    output logic [8:0] lfsr_o
);

    logic [8:0] lfsr_q;
    logic [8:0] lfsr_d;

    assign lfsr_d = {lfsr_q[7:0], lfsr_q[8] ^ lfsr_q[4]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign lfsr_o = lfsr_q;

endmodule

// File: rtl/pipe_scheduler.sv
// Game-level pipe sequencer: IDLE/RUN/HALT state, three pipe slots, spawn spacing and score.
// Slot outputs are packed 10 bits per slot for the VGA renderer.
//
//   state | meaning
//   IDLE  | slots, score and distance held clear; start launches slot0
//   RUN   | pipes retire, move, score and spawn on each move_tick
//   HALT  | everything frozen after a collision; start returns to IDLE
module pipe_scheduler #(
    parameter int unsigned WIDTH_PIPE = flappy_pkg::WIDTH_PIPE,
    parameter int unsigned MAX_X      = flappy_pkg::MAX_X,
    parameter int unsigned MIN_X      = flappy_pkg::MIN_X,
    parameter int unsigned MIN_Y      = flappy_pkg::MIN_Y,
    parameter int unsigned SPACING    = flappy_pkg::SPACING,
    parameter int unsigned BIRD_X     = flappy_pkg::BIRD_X,
    parameter int unsigned H_LO       = flappy_pkg::H_LO,
    parameter int unsigned H_HI       = flappy_pkg::H_HI,
    parameter int unsigned H_DEF      = flappy_pkg::H_DEF
) (
    input  logic        system_clk,
    input  logic        reset,
    input  logic        start,
    input  logic        collide,
    input  logic        move_tick,
    input  logic [1:0]  velocity,
    output logic [1:0]  state,
    output logic [2:0]  pipe_active,
    output logic [29:0] pipe_l,
    output logic [29:0] pipe_b,
    output logic [9:0]  pipe_t,
    output logic [7:0]  score
);
    import flappy_pkg::*;

    localparam logic [9:0] WP_W      = 10'(WIDTH_PIPE);
    localparam logic [9:0] MAX_X_W   = 10'(MAX_X);
    localparam logic [9:0] MIN_X_W   = 10'(MIN_X);
    localparam logic [9:0] MIN_Y_W   = 10'(MIN_Y);
    localparam logic [9:0] SPACING_W = 10'(SPACING);
    localparam logic [9:0] BIRD_X_W  = 10'(BIRD_X);
    localparam logic [9:0] H_LO_W    = 10'(H_LO);
    localparam logic [9:0] H_HI_W    = 10'(H_HI);
    localparam logic [9:0] H_DEF_W   = 10'(H_DEF);

    logic [1:0]  state_q, state_d;
    logic [7:0]  score_q, score_d;
    logic [9:0]  dist_q, dist_d;

    logic [8:0]  lfsr_w;
    logic [9:0]  height_w;
    logic [9:0]  vel_w;
    logic        run_tick;
    logic        start_run;
    logic        clear_all;

    logic [N_SLOTS-1:0] retire_w;
    logic [N_SLOTS-1:0] hit_w;
    logic [N_SLOTS-1:0] free_w;
    logic [N_SLOTS-1:0] spawn_sel;

    logic [9:0]  dist_sum;
    logic [9:0]  dist_new;
    logic        dist_full;
    logic [1:0]  hit_cnt;
    logic [8:0]  score_sum;

    pipe_lfsr #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk    (system_clk),
        .reset  (reset),
        .lfsr_o (lfsr_w)
    );

    assign height_w = height_sample(lfsr_w, H_LO_W, H_HI_W, H_DEF_W);
    assign vel_w    = {8'd0, velocity};

    // Collision wins over a coincident move_tick, so a crash frame never moves or scores.
    assign run_tick  = (state_q == ST_RUN) && !collide && move_tick;
    assign start_run = (state_q == ST_IDLE) && start;
    assign clear_all = (state_q == ST_IDLE) || ((state_q == ST_HALT) && start);

    assign dist_sum  = dist_q + vel_w;
    assign dist_new  = (dist_sum >= SPACING_W) ? SPACING_W : dist_sum;
    assign dist_full = (dist_new >= SPACING_W);

    // A slot retiring on this tick is already free for the spawn of the same tick.
    always_comb begin
        spawn_sel = '0;
        if (run_tick && dist_full) begin
            for (int i = 0; i < N_SLOTS; i++) begin
                if (free_w[i] && (spawn_sel == '0)) begin
                    spawn_sel[i] = 1'b1;
                end
            end
        end
    end

    for (genvar g = 0; g < N_SLOTS; g++) begin : g_slot
        logic       active_q, active_d;
        logic       scored_q, scored_d;
        logic [9:0] l_q, l_d;
        logic [9:0] b_q, b_d;
        logic [9:0] l_moved;

        assign l_moved     = l_q - vel_w;
        assign retire_w[g] = active_q && ((l_q + WP_W) <= MIN_X_W);
        assign hit_w[g]    = active_q && !retire_w[g] && !scored_q
                             && ((l_moved + WP_W) < BIRD_X_W);
        assign free_w[g]   = !active_q || retire_w[g];

        always_comb begin
            active_d = active_q;
            scored_d = scored_q;
            l_d      = l_q;
            b_d      = b_q;
            if (clear_all) begin
                active_d = 1'b0;
                scored_d = 1'b0;
                l_d      = '0;
                b_d      = '0;
                if ((g == 0) && start_run) begin
                    active_d = 1'b1;
                    l_d      = MAX_X_W;
                    b_d      = height_w;
                end
            end else if (run_tick) begin
                if (spawn_sel[g]) begin
                    active_d = 1'b1;
                    scored_d = 1'b0;
                    l_d      = MAX_X_W;
                    b_d      = height_w;
                end else if (retire_w[g]) begin
                    active_d = 1'b0;
                end else if (active_q) begin
                    l_d = l_moved;
                    if (hit_w[g]) begin
                        scored_d = 1'b1;
                    end
                end
            end
        end

        always_ff @(posedge system_clk or posedge reset) begin
            if (reset) begin
                active_q <= 1'b0;
                scored_q <= 1'b0;
                l_q      <= '0;
                b_q      <= '0;
            end else begin
                active_q <= active_d;
                scored_q <= scored_d;
                l_q      <= l_d;
                b_q      <= b_d;
            end
        end

        assign pipe_active[g]      = active_q;
        assign pipe_l[10*g +: 10]  = l_q;
        assign pipe_b[10*g +: 10]  = b_q;
    end

    assign hit_cnt   = {1'b0, hit_w[0]} + {1'b0, hit_w[1]} + {1'b0, hit_w[2]};
    assign score_sum = {1'b0, score_q} + {7'd0, hit_cnt};

    always_comb begin
        state_d = state_q;
        score_d = score_q;
        dist_d  = dist_q;
        case (state_q)
            ST_IDLE: begin
                score_d = '0;
                dist_d  = '0;
                if (start) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (collide) begin
                    state_d = ST_HALT;
                end else if (move_tick) begin
                    score_d = score_sum[8] ? 8'hFF : score_sum[7:0];
                    dist_d  = (spawn_sel != '0) ? 10'd0 : dist_new;
                end
            end
            ST_HALT: begin
                if (start) begin
                    state_d = ST_IDLE;
                    score_d = '0;
                    dist_d  = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                score_d = '0;
                dist_d  = '0;
            end
        endcase
    end

    always_ff @(posedge system_clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            score_q <= '0;
            dist_q  <= '0;
        end else begin
            state_q <= state_d;
            score_q <= score_d;
            dist_q  <= dist_d;
        end
    end

    assign state  = state_q;
    assign score  = score_q;
    assign pipe_t = MIN_Y_W;

endmodule
